// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency ALU.
// Grants are combinational; a {valid,id} shift line routes each result back.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req0_op,
  input  logic [4:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_out,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [63:0] resp_data,
  output logic        busy,
  output logic [15:0] issue_count
);

  logic               ptr;
  logic               grant_any;
  logic               grant_id;
  logic [ALU_LAT-1:0] stage_valid;
  logic [ALU_LAT-1:0] stage_id;

  // The pointer only matters when both requesters compete.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      req0_ready = ~ptr;
      req1_ready = ptr;
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  assign grant_any = req0_ready | req1_ready;
  assign grant_id  = req1_ready;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (req0_ready) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (req1_ready) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      stage_valid <= '0;
      stage_id    <= '0;
      issue_count <= '0;
    end else begin
      if (grant_any) begin
        ptr         <= ~grant_id;
        issue_count <= issue_count + 16'd1;
      end
      stage_valid[0] <= grant_any;
      stage_id[0]    <= grant_id;
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_id[i]    <= stage_id[i-1];
      end
    end
  end

  // Last tracking stage lines up with the ALU result for the same issue.
  assign resp0_valid = stage_valid[ALU_LAT-1] & ~stage_id[ALU_LAT-1];
  assign resp1_valid = stage_valid[ALU_LAT-1] &  stage_id[ALU_LAT-1];
  assign resp_data   = stage_valid[ALU_LAT-1] ? alu_out : '0;
  assign busy        = |stage_valid;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, ALU result latency in cycles from operand presentation to valid alu_out; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  operands of requester N.
REQ-007 req0_op, req1_op  input  5 each  ALU opcode of requester N.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-009 alu_op  output  5  opcode driven to the shared ALU.
REQ-010 alu_out  input  64  result from the shared ALU, valid ALU_LAT cycles after issue.
REQ-011 resp0_valid, resp1_valid  output  1 each  one-cycle pulse: result for requester N present on resp_data.
REQ-012 resp_data  output  64  result routed to the requester flagged by respN_valid.
REQ-013 busy  output  1  at least one issued operation is still in flight.
REQ-014 issue_count  output  16  total operations accepted since reset.

Function
REQ-015 Transfer: requester N's operation is accepted on any rising edge where reqN_valid=1 and reqN_ready=1.
REQ-016 At most one of req0_ready/req1_ready is 1 in any cycle; readies are combinational from valids and the priority pointer.
REQ-017 Only one valid: that requester is granted, regardless of pointer.
REQ-018 Both valid: the requester named by the 1-bit priority pointer is granted.
REQ-019 Pointer update: after a grant to N, pointer = other requester; no grant leaves the pointer unchanged.
REQ-020 Neither valid: both readies 0; alu_a=0, alu_b=0, alu_op=5'b00000.
REQ-021 Grant cycle: alu_a/alu_b/alu_op equal the granted requester's a/b/op in the same cycle (combinational mux, zero added latency).
REQ-022 Issue tracking: ALU_LAT-deep shift register of {valid, id}; each accepted issue enters {1, N}; idle cycles enter {0, x}; advances every cycle.
REQ-023 Response: when the last tracking stage holds {1, N}, respN_valid=1 for exactly that cycle and resp_data=alu_out; otherwise both respN_valid=0 and resp_data=0.
REQ-024 Throughput: one issue per cycle sustained; responses return in issue order, one per cycle, with no backpressure on responses.
REQ-025 Latency: issue accepted on edge k produces respN_valid in the cycle following edge k+ALU_LAT-1 (ALU_LAT=1: cycle after issue edge).
REQ-026 Both valid every cycle: grants alternate 0,1,0,1,... after reset; neither requester waits more than one cycle.
REQ-027 busy = OR of all tracking-stage valid bits (registered state only, not the current-cycle grant).
REQ-028 issue_count increments by 1 on each accepted transfer; wraps 16'hFFFF -> 16'h0000 without flag.
REQ-029 Requester rule (not checked): reqN_a/b/op stable while reqN_valid=1 and reqN_ready=0.

Reset
REQ-030 While rst_n=0 at a rising edge: pointer=0, all tracking valid bits=0, issue_count=0.
REQ-031 During and after reset: busy=0, resp0_valid=resp1_valid=0, resp_data=0; readies follow REQ-016..020 with pointer=0.
REQ-032 Reset mid-operation: in-flight operations are discarded; no respN_valid pulse for any operation issued before the reset edge.
REQ-033 First cycle with rst_n=1: arbitration and issue operate normally.

Verification
REQ-034 ALU_LAT=1, req0 only, a=32'hF0F0F0FF, b=32'h0F0F0F03, op=5'b01000 -> req0_ready=1, alu ports match same cycle, resp0_valid pulses next cycle with resp_data=alu_out, issue_count=1.
REQ-035 Both valid held 6 cycles after reset -> grants 0,1,0,1,0,1; resp0/resp1 pulses alternate; issue_count=6.
REQ-036 ALU_LAT=3, req1 issues 3 back-to-back ops -> resp1_valid high 3 consecutive cycles starting 3 cycles after first issue; busy=1 from cycle after first issue until last response cycle.
REQ-037 Issue 2 ops, assert rst_n=0 for 1 cycle before responses -> no respN_valid pulses, busy=0, issue_count=0, pointer=0.
REQ-038 Preload issue_count to 16'hFFFE via 2 issues short of wrap (force) then 2 issues -> issue_count reads 16'hFFFF then 16'h0000.
REQ-039 No valids for 5 cycles -> readies 0, alu_op=5'b00000, alu_a=alu_b=0, pointer unchanged.
